// File: rtl/_pkg_riscv_defines.sv
// Shared RISC-V execute-stage definitions: datapath width and ALU opcode set.
// Pure declarations, no logic, no latency.
// No flow control of its own; consumed by the ALU and its controller.
package _pkg_riscv_defines;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

endpackage

// File: rtl/alu_iterative_pkg.sv
// Iterative ALU local types, default shift step and single-cycle op helpers.
// Functions are purely combinational, no latency.
// No flow control; helpers only.
package alu_iterative_pkg;

    import _pkg_riscv_defines::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } alu_state_t;

    // Bits shifted per CALC cycle; keeps the per-cycle shifter to a few mux levels.
    localparam int ALU_SHIFT_STEP = 4;

    function automatic logic is_shift(input alu_op_t op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    // All ops that finish in the accept cycle. Unknown encodings yield zero.
    function automatic logic [DATA_WIDTH-1:0] alu_compute(
        input alu_op_t               op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLT:  r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: r = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_iterative_shift_step.sv
// One shift iteration: moves acc by 0..SHIFT_STEP bits left/right/arithmetic.
// Purely combinational, zero latency.
// No flow control; the parent decides when the output is captured.
module alu_shift_step
    import _pkg_riscv_defines::*;
    import alu_iterative_pkg::*;
#(
    parameter int SHIFT_STEP = ALU_SHIFT_STEP
) (
    input  logic [DATA_WIDTH-1:0]       acc,
    input  logic [$clog2(SHIFT_STEP):0] amt,
    input  alu_op_t                     op,
    output logic [DATA_WIDTH-1:0]       shifted
);

    // SRA replicates the current sign bit of acc on every partial step.
    always_comb begin
        shifted = acc;
        case (op)
            ALU_SLL: shifted = acc << amt;
            ALU_SRL: shifted = acc >> amt;
            ALU_SRA: shifted = $signed(acc) >>> amt;
            default: shifted = acc;
        endcase
    end

endmodule

// File: rtl/alu_iterative.sv
// ALU responder: single-cycle logic/arith ops, shifts iterated SHIFT_STEP bits per cycle.
// resp_valid at cycle 1 for non-shift/zero shifts, 1 + ceil(shamt/SHIFT_STEP) for shifts.
// resp_ready low while busy (CALC/RESP); response cannot be stalled by the master.
module alu_iterative
    import _pkg_riscv_defines::*;
    import alu_iterative_pkg::*;
#(
    parameter int SHIFT_STEP = ALU_SHIFT_STEP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  resp_ready,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    input  alu_op_t               alu_op,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);
    localparam int STEP_W      = $clog2(SHIFT_STEP) + 1;

    alu_state_t             state_q,  state_d;
    logic [DATA_WIDTH-1:0]  acc_q,    acc_d;
    logic [SHAMT_WIDTH-1:0] rem_q,    rem_d;
    alu_op_t                op_q,     op_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;

    logic [SHAMT_WIDTH-1:0] shamt_in;
    logic [SHAMT_WIDTH-1:0] step;
    logic [SHAMT_WIDTH-1:0] rem_next;
    logic [DATA_WIDTH-1:0]  shifted;

    // Only the low bits of operand2 count as a shift amount.
    assign shamt_in = operand2[SHAMT_WIDTH-1:0];

    // Per-iteration amount: whatever is left, capped at SHIFT_STEP.
    always_comb begin
        step = (rem_q < SHAMT_WIDTH'(SHIFT_STEP)) ? rem_q : SHAMT_WIDTH'(SHIFT_STEP);
    end

    assign rem_next = rem_q - step;

    alu_shift_step #(
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift_step (
        .acc     (acc_q),
        .amt     (STEP_W'(step)),
        .op      (op_q),
        .shifted (shifted)
    );

    // Next-state and datapath: result is only reloaded on the transition into RESP.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!is_shift(alu_op)) begin
                        result_d = alu_compute(alu_op, operand1, operand2);
                        state_d  = RESP;
                    end else if (shamt_in == '0) begin
                        result_d = operand1;
                        state_d  = RESP;
                    end else begin
                        acc_d   = operand1;
                        rem_d   = shamt_in;
                        op_d    = alu_op;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = shifted;
                rem_d = rem_next;
                if (rem_next == '0) begin
                    result_d = shifted;
                    state_d  = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            rem_q    <= '0;
            op_q     <= ALU_ADD;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign resp_ready = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign result     = result_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Directed self-checking bench for alu_iterative with SHIFT_STEP = 4.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Master never stalls responses; bounded waits count as failures.
module tb_alu_iterative;

    import _pkg_riscv_defines::*;
    import alu_iterative_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        resp_ready;
    logic [31:0] operand1;
    logic [31:0] operand2;
    alu_op_t     alu_op;
    logic        resp_valid;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_res;

    alu_iterative #(
        .SHIFT_STEP (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .resp_ready (resp_ready),
        .operand1   (operand1),
        .operand2   (operand2),
        .alu_op     (alu_op),
        .resp_valid (resp_valid),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request with inputs scrambled after accept; checks latency, busy,
    // result hold while busy, result value and single-cycle strobe.
    task automatic run(input string tag, input alu_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        int   lat;
        logic busy_ok;
        logic hold_ok;
        @(negedge clk);
        chk({tag, "_rdy_idle"}, {31'd0, resp_ready}, 32'd1);
        alu_op    = op;
        operand1  = a;
        operand2  = b;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        alu_op    = ALU_ADD;
        operand1  = 32'hDEAD_BEEF;
        operand2  = 32'hFFFF_FFFF;
        lat     = 1;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (resp_valid !== 1'b1 && lat < 40) begin
            if (resp_ready !== 1'b0) busy_ok = 1'b0;
            if (result !== last_res) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (resp_ready !== 1'b0) busy_ok = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
        chk({tag, "_result"}, result, exp_res);
        @(negedge clk);
        chk({tag, "_pulse_end"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_result_kept"}, result, exp_res);
        last_res = exp_res;
    endtask

    initial begin
        int   seen;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        operand1  = '0;
        operand2  = '0;
        alu_op    = ALU_ADD;
        last_res  = '0;

        // Reset state
        #12;
        chk("rst_ready",  {31'd0, resp_ready}, 32'd1);
        chk("rst_valid",  {31'd0, resp_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle ops
        run("add",  ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000);
        run("sub",  ALU_SUB,  32'h0000_0000, 32'h0000_0001, 1, 32'hFFFF_FFFF);
        run("slt",  ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0001);
        run("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0000);
        run("and",  ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000);
        run("or",   ALU_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hFFF0_FFF0);
        run("undef", alu_op_t'(4'd12), 32'h1234_5678, 32'h1111_1111, 1, 32'h0000_0000);

        // Shifts
        run("sra31", ALU_SRA, 32'h8000_0000, 32'h0000_001F, 9, 32'hFFFF_FFFF);
        run("sll0",  ALU_SLL, 32'h0000_0001, 32'hFFFF_FFE0, 1, 32'h0000_0001);
        run("srl5",  ALU_SRL, 32'hF000_0000, 32'h0000_0005, 3, 32'h0780_0000);
        run("sll4",  ALU_SLL, 32'h0000_0003, 32'h0000_0004, 2, 32'h0000_0030);
        run("xor",   ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'h0FF0_0FF0);

        // Back-to-back with req_valid held high and operands changed mid-shift
        @(negedge clk);
        chk("b2b_rdy0", {31'd0, resp_ready}, 32'd1);
        alu_op    = ALU_SLL;
        operand1  = 32'h0000_0001;
        operand2  = 32'h0000_0008;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        alu_op   = ALU_ADD;
        operand1 = 32'h0000_0005;
        operand2 = 32'h0000_0006;
        chk("b2b_c1_rdy",    {31'd0, resp_ready}, 32'd0);
        chk("b2b_c1_result", result, 32'h0FF0_0FF0);
        @(negedge clk);
        chk("b2b_c2_vld",    {31'd0, resp_valid}, 32'd0);
        chk("b2b_c2_result", result, 32'h0FF0_0FF0);
        @(negedge clk);
        chk("b2b_c3_vld",    {31'd0, resp_valid}, 32'd1);
        chk("b2b_c3_rdy",    {31'd0, resp_ready}, 32'd0);
        chk("b2b_c3_result", result, 32'h0000_0100);
        @(negedge clk);
        chk("b2b_c4_vld",    {31'd0, resp_valid}, 32'd0);
        chk("b2b_c4_rdy",    {31'd0, resp_ready}, 32'd1);
        chk("b2b_c4_result", result, 32'h0000_0100);
        @(negedge clk);
        chk("b2b_c5_vld",    {31'd0, resp_valid}, 32'd1);
        chk("b2b_c5_result", result, 32'h0000_000B);
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_c6_vld",    {31'd0, resp_valid}, 32'd0);
        chk("b2b_c6_result", result, 32'h0000_000B);

        // Reset in the middle of a long shift
        alu_op    = ALU_SRL;
        operand1  = 32'h8000_0000;
        operand2  = 32'h0000_001F;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", {31'd0, resp_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_ready",  {31'd0, resp_ready}, 32'd1);
        chk("mid_rst_valid",  {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen++;
        end
        chk("mid_no_resp", 32'(seen), 32'd0);
        last_res = 32'd0;
        run("add_after_rst", ALU_ADD, 32'h0000_0002, 32'h0000_0003, 1, 32'h0000_0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so a stuck design can never hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
